// File: rtl/branch_predictor_gshare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_gshare_pkg
// Description : Shared types for the gshare branch predictor. Contains the
//               RV32I word type, the 2-bit saturating counter encoding and
//               the reset-walk FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_predictor_gshare_pkg;

    typedef logic [31:0] rv32i_word;

    // Counter encoding: the prediction is bit[1].
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_t;

    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    // Value written to every entry by the reset walk.
    localparam bp_cnt_t c_CNT_RESET = WNT;

endpackage : branch_predictor_gshare_pkg
`default_nettype wire

// File: rtl/branch_predictor_gshare_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_gshare_if
// Description : Fetch/execute-side bundle of the gshare predictor.
//               master : pipeline (drives requests and resolved updates)
//               slave  : predictor
//               Signals: ready_o, pred_req_i, pred_pc_i, pred_valid_o,
//               pred_taken_o, pred_idx_o, upd_valid_i, upd_idx_i, upd_taken_i
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_gshare_if #(
    parameter int IDX_BITS = 7
);
    import branch_predictor_gshare_pkg::*;

    logic                ready_o;
    logic                pred_req_i;
    rv32i_word           pred_pc_i;
    logic                pred_valid_o;
    logic                pred_taken_o;
    logic [IDX_BITS-1:0] pred_idx_o;
    logic                upd_valid_i;
    logic [IDX_BITS-1:0] upd_idx_i;
    logic                upd_taken_i;

    modport master (
        input  ready_o, pred_valid_o, pred_taken_o, pred_idx_o,
        output pred_req_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i
    );

    modport slave (
        output ready_o, pred_valid_o, pred_taken_o, pred_idx_o,
        input  pred_req_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i
    );

endinterface : branch_predictor_gshare_if
`default_nettype wire

// File: rtl/branch_predictor_gshare_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter
// Description : Combinational next-count for a 2-bit saturating counter.
//               i_cnt   : current counter
//               i_taken : resolved branch outcome
//               o_cnt   : counter after training (saturates at SNT / ST)
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter
    import branch_predictor_gshare_pkg::*;
(
    input  bp_cnt_t i_cnt,
    input  logic    i_taken,
    output bp_cnt_t o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        case (i_cnt)
            SNT:     o_cnt = i_taken ? WNT : SNT;
            WNT:     o_cnt = i_taken ? WT  : SNT;
            WT:      o_cnt = i_taken ? ST  : WNT;
            ST:      o_cnt = i_taken ? ST  : WT;
            default: o_cnt = i_cnt;
        endcase
    end

endmodule : bp_sat_counter
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_gshare
// Description : Gshare direction predictor. A table of 2-bit saturating
//               counters is indexed by PC[IDX_BITS+1:2] XOR the global
//               history register. After reset a walk writes WNT into every
//               entry; requests and updates are ignored until it completes.
//               clk, rst : clock, synchronous active-high reset
//               bp       : slave side of branch_predictor_gshare_if
//                          (fetch request/response, execute update)
//               HIST_BITS must not exceed IDX_BITS.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_gshare
    import branch_predictor_gshare_pkg::*;
#(
    parameter int IDX_BITS  = 7,
    parameter int HIST_BITS = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    branch_predictor_gshare_if.slave       bp
);

    localparam int c_DEPTH = 2 ** IDX_BITS;

    bp_state_t           r_state;
    logic [IDX_BITS-1:0] r_ptr;
    logic [HIST_BITS-1:0] r_ghr;
    bp_cnt_t             r_table [c_DEPTH];
    logic                r_pred_valid;
    logic                r_pred_taken;
    logic [IDX_BITS-1:0] r_pred_idx;

    logic [HIST_BITS-1:0] w_ghr_next;
    logic [IDX_BITS-1:0]  w_hist_ext;
    logic [IDX_BITS-1:0]  w_idx;
    logic                 w_run;
    logic                 w_accept;
    bp_cnt_t              w_upd_next;
    rv32i_word            w_pc;
    logic [31-IDX_BITS:0] w_unused_pc;

    assign w_pc        = bp.pred_pc_i;
    assign w_unused_pc = {w_pc[31:IDX_BITS+2], w_pc[1:0]};

    // History occupies the low index bits; upper bits come from the PC only.
    if (HIST_BITS == IDX_BITS) begin : g_hist_full
        assign w_hist_ext = r_ghr;
    end else begin : g_hist_pad
        assign w_hist_ext = {{(IDX_BITS-HIST_BITS){1'b0}}, r_ghr};
    end

    if (HIST_BITS > 1) begin : g_ghr_shift
        assign w_ghr_next = {r_ghr[HIST_BITS-2:0], bp.upd_taken_i};
    end else begin : g_ghr_single
        assign w_ghr_next = bp.upd_taken_i;
    end

    assign w_idx    = w_pc[IDX_BITS+1:2] ^ w_hist_ext;
    assign w_run    = (r_state == BP_RUN);
    assign w_accept = bp.pred_req_i && w_run;

    bp_sat_counter u_sat_counter (
        .i_cnt   (r_table[bp.upd_idx_i]),
        .i_taken (bp.upd_taken_i),
        .o_cnt   (w_upd_next)
    );

    // Single write port shared by the reset walk and training. Reads in the
    // same cycle see the old value, so a colliding predict gets the
    // pre-update counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == BP_INIT) begin
                r_table[r_ptr] <= c_CNT_RESET;
            end else if (bp.upd_valid_i) begin
                r_table[bp.upd_idx_i] <= w_upd_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BP_INIT;
            r_ptr        <= '0;
            r_ghr        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
        end else begin
            r_pred_valid <= w_accept;
            if (w_accept) begin
                r_pred_taken <= r_table[w_idx][1];
                r_pred_idx   <= w_idx;
            end

            case (r_state)
                BP_INIT: begin
                    r_ptr <= r_ptr + IDX_BITS'(1);
                    if (r_ptr == IDX_BITS'(c_DEPTH - 1)) begin
                        r_state <= BP_RUN;
                    end
                end
                BP_RUN: begin
                    // History advances only on resolved branches.
                    if (bp.upd_valid_i) begin
                        r_ghr <= w_ghr_next;
                    end
                end
                default: r_state <= BP_INIT;
            endcase
        end
    end

    assign bp.ready_o      = w_run;
    assign bp.pred_valid_o = r_pred_valid;
    assign bp.pred_taken_o = r_pred_taken;
    assign bp.pred_idx_o   = r_pred_idx;

endmodule : branch_predictor_gshare
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_gshare
// Description : Self-checking bench for branch_predictor_gshare. Directed
//               stimulus pushes expected responses into a queue; a monitor
//               on the falling edge pops and compares each response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_gshare;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    branch_predictor_gshare_if #(.IDX_BITS(7)) bp_if ();

    branch_predictor_gshare #(
        .IDX_BITS  (7),
        .HIST_BITS (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    typedef struct {
        logic       taken;
        logic [6:0] idx;
        string      name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, req);
        end
    endtask

    // Monitor: every accepted request must produce exactly one response.
    always @(negedge clk) begin
        exp_t e;
        if (bp_if.pred_valid_o === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got pred_valid_o=1 required 0 at %0t", $time);
            end else begin
                e = q.pop_front();
                chk({e.name, "_taken"}, 32'(bp_if.pred_taken_o), 32'(e.taken));
                chk({e.name, "_idx"},   32'(bp_if.pred_idx_o),   32'(e.idx));
            end
        end else if (q.size() != 0) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s_missing: got pred_valid_o=%b required 1 at %0t",
                     e.name, bp_if.pred_valid_o, $time);
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step(input logic req, input logic [31:0] pc, input logic upd,
                        input logic [6:0] uidx, input logic ut,
                        input logic et, input logic [6:0] ei, input string nm);
        bp_if.pred_req_i  = req;
        bp_if.pred_pc_i   = pc;
        bp_if.upd_valid_i = upd;
        bp_if.upd_idx_i   = uidx;
        bp_if.upd_taken_i = ut;
        @(posedge clk);
        #1;
        if (req) q.push_back('{et, ei, nm});
        bp_if.pred_req_i  = 1'b0;
        bp_if.upd_valid_i = 1'b0;
        bp_if.upd_taken_i = 1'b0;
    endtask

    task automatic predict(input logic [31:0] pc, input logic et, input logic [6:0] ei, input string nm);
        step(1'b1, pc, 1'b0, 7'd0, 1'b0, et, ei, nm);
    endtask

    task automatic update(input logic [6:0] idx, input logic t);
        step(1'b0, 32'd0, 1'b1, idx, t, 1'b0, 7'd0, "");
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({nm, "_ready"},      32'(bp_if.ready_o),      32'd0);
        chk({nm, "_pred_valid"}, 32'(bp_if.pred_valid_o), 32'd0);
        chk({nm, "_pred_taken"}, 32'(bp_if.pred_taken_o), 32'd0);
        chk({nm, "_pred_idx"},   32'(bp_if.pred_idx_o),   32'd0);
    endtask

    // Counts cycles with ready_o low after rst falls; optionally keeps the
    // request and update inputs asserted for the whole walk.
    task automatic wait_ready(input logic junk, input string nm);
        int n;
        n = 0;
        while (bp_if.ready_o !== 1'b1 && n < 300) begin
            bp_if.pred_req_i  = junk;
            bp_if.pred_pc_i   = 32'h0000_0014;
            bp_if.upd_valid_i = junk;
            bp_if.upd_idx_i   = 7'h05;
            bp_if.upd_taken_i = junk;
            n++;
            @(posedge clk);
            #1;
        end
        bp_if.pred_req_i  = 1'b0;
        bp_if.upd_valid_i = 1'b0;
        bp_if.upd_taken_i = 1'b0;
        chk({nm, "_init_cycles"}, 32'(n), 32'd128);
    endtask

    initial begin
        bp_if.pred_req_i  = 1'b0;
        bp_if.pred_pc_i   = '0;
        bp_if.upd_valid_i = 1'b0;
        bp_if.upd_idx_i   = '0;
        bp_if.upd_taken_i = 1'b0;

        // Reset and walk; then every entry must read WNT with GHR=0.
        do_reset("rst1");
        wait_ready(1'b0, "walk1");
        for (int i = 0; i < 128; i++) begin
            predict(32'(i) << 2, 1'b0, 7'(i), "walk_entry");
        end

        // PC 0x40 with empty history -> index 0x10.
        predict(32'h0000_0040, 1'b0, 7'h10, "pc40");

        // Train 0x10: 1->2->3->3 (GHR -> 0x07), predict via PC 0x5C.
        update(7'h10, 1'b1);
        update(7'h10, 1'b1);
        update(7'h10, 1'b1);
        predict(32'h0000_005C, 1'b1, 7'h10, "sat_hi");
        // 3->2 (GHR 0x0E): still taken; PC 0x78 maps to 0x10.
        update(7'h10, 1'b0);
        predict(32'h0000_0078, 1'b1, 7'h10, "dec_wt");
        // 2->1 (GHR 0x1C): not taken; PC 0x30 maps to 0x10.
        update(7'h10, 1'b0);
        predict(32'h0000_0030, 1'b0, 7'h10, "dec_wnt");
        // 1->2 (GHR 0x39): PC 0xA4 maps to 0x10.
        update(7'h10, 1'b1);
        predict(32'h0000_00A4, 1'b1, 7'h10, "inc_wt");
        step(1'b0, 32'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, "");

        // Reset mid-walk at cycle 60 restarts the walk.
        do_reset("rst2");
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midwalk_ready", 32'(bp_if.ready_o), 32'd0);
        do_reset("rst3");
        // Requests and updates held high through the walk must be ignored.
        wait_ready(1'b1, "walk3");

        // Entry 0x10 re-walked to WNT, GHR back to 0.
        predict(32'h0000_0040, 1'b0, 7'h10, "rewalk_pc40");

        // Same-cycle predict + update on index 0x05: pre-update counter.
        step(1'b1, 32'h0000_0014, 1'b1, 7'h05, 1'b1, 1'b0, 7'h05, "collide");
        // GHR now 1: same PC lands on 0x04.
        predict(32'h0000_0014, 1'b0, 7'h04, "ghr_xor");
        // PC 0x10 ^ GHR 1 -> 0x05, now WT.
        predict(32'h0000_0010, 1'b1, 7'h05, "collide_trained");

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_branch_predictor_gshare
`default_nettype wire
